xadc_drp_arbiter: RTL and testbench

- Shares the single XADC Wizard DRP port (den/dwe/daddr/di/do/drdy) between N independent requesters, e.g. the channel-scan sequencer feeding the LED/VGA display path and a configuration-register writer.
- Arbitrates round-robin, issues exactly one DRP transaction at a time, returns read data with a one-cycle ack, and recovers from a missing drdy via a timeout.
- Sits between the requesters and the xadc_wiz_0 instance; it is the only driver of the XADC DRP inputs.

---
 rtl/xadc_pkg.sv | 26 ++
 rtl/rr_picker.sv | 40 ++++
 rtl/xadc_drp_arbiter.sv | 136 +++++++++++++
 tb/tb_xadc_drp_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// ============================================================================
// xadc_pkg : shared definitions for the XADC DRP arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package xadc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  localparam logic [DRP_AW-1:0] VAUX6  = 7'h16;
  localparam logic [DRP_AW-1:0] VAUX7  = 7'h17;
  localparam logic [DRP_AW-1:0] VAUX14 = 7'h1E;
  localparam logic [DRP_AW-1:0] VAUX15 = 7'h1F;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// rr_picker : combinational round-robin picker (first set bit at/after ptr)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     valid
);

  localparam int IW = $clog2(N_REQ);

  logic [IW:0] cand;

  // Scan farthest-first so the candidate closest to ptr overwrites the rest.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (req[cand[IW-1:0]]) begin
        idx = cand[IW-1:0];
      end
    end
    valid = |req;
    grant = valid ? (N_REQ'(1) << idx) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/xadc_drp_arbiter.sv
// ============================================================================
// xadc_drp_arbiter : round-robin sharing of one XADC DRP port with timeout
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          req,
  input  logic [DRP_AW*N_REQ-1:0]   req_addr,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [DRP_DW*N_REQ-1:0]   req_di,
  output logic [N_REQ-1:0]          ack,
  output logic [DRP_DW-1:0]         ack_do,
  output logic                      ack_err,
  output logic                      busy,
  output logic                      drp_den,
  output logic                      drp_dwe,
  output logic [DRP_AW-1:0]         drp_daddr,
  output logic [DRP_DW-1:0]         drp_di,
  input  logic [DRP_DW-1:0]         drp_do,
  input  logic                      drp_drdy
);

  localparam int IW = $clog2(N_REQ);

  state_t              state, state_nxt;
  logic [IW-1:0]       ptr, win_idx, pick_idx;
  logic [N_REQ-1:0]    win_oh, pick_grant;
  logic                pick_valid;
  logic [DRP_AW-1:0]   g_addr;
  logic                g_we;
  logic [DRP_DW-1:0]   g_di;
  logic [15:0]         wait_cnt;
  logic [DRP_DW-1:0]   res_do;
  logic                res_err;
  logic                timed_out;

  logic [DRP_AW-1:0]   addr_arr [N_REQ];
  logic [DRP_DW-1:0]   di_arr   [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[DRP_AW*i +: DRP_AW];
    assign di_arr[i]   = req_di[DRP_DW*i +: DRP_DW];
  end

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // The TIMEOUT-th WAIT cycle sees wait_cnt == TIMEOUT-1.
  assign timed_out = (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      ptr      <= '0;
      win_idx  <= '0;
      win_oh   <= '0;
      g_addr   <= '0;
      g_we     <= 1'b0;
      g_di     <= '0;
      wait_cnt <= '0;
      res_do   <= '0;
      res_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            win_idx <= pick_idx;
            win_oh  <= pick_grant;
            g_addr  <= addr_arr[pick_idx];
            g_we    <= req_we[pick_idx];
            g_di    <= di_arr[pick_idx];
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (drp_drdy) begin
            res_do  <= g_we ? '0 : drp_do;
            res_err <= 1'b0;
          end else if (timed_out) begin
            res_do  <= '0;
            res_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_DONE: ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    ack       = '0;
    ack_do    = '0;
    ack_err   = 1'b0;
    drp_den   = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (pick_valid) state_nxt = S_ISSUE;
      S_ISSUE: begin
        drp_den   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:  if (drp_drdy || timed_out) state_nxt = S_DONE;
      S_DONE: begin
        ack       = win_oh;
        ack_do    = res_do;
        ack_err   = res_err;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign drp_dwe   = g_we;
  assign drp_daddr = g_addr;
  assign drp_di    = g_di;

endmodule

`default_nettype wire

// File: tb/tb_xadc_drp_arbiter.sv
// ============================================================================
// tb_xadc_drp_arbiter : directed table-driven bench for xadc_drp_arbiter
// Revision            : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_xadc_drp_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req, req_we;
  logic [27:0] req_addr;
  logic [63:0] req_di;
  logic [3:0]  ack;
  logic [15:0] ack_do;
  logic        ack_err, busy, drp_den, drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di, drp_do;
  logic        drp_drdy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0]  addr_tab [4] = '{7'h1E, 7'h16, 7'h41, 7'h1F};
  logic [15:0] di_tab   [4] = '{16'h1111, 16'h2222, 16'h2000, 16'h4444};

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    int          lat;      // drdy this many cycles after den; -1 = never
    logic [15:0] rdata;
    int          exp_idx;
    logic [15:0] exp_do;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  xadc_drp_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_di    (req_di),
    .ack       (ack),
    .ack_do    (ack_do),
    .ack_err   (ack_err),
    .busy      (busy),
    .drp_den   (drp_den),
    .drp_dwe   (drp_dwe),
    .drp_daddr (drp_daddr),
    .drp_di    (drp_di),
    .drp_do    (drp_do),
    .drp_drdy  (drp_drdy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  // Wait for den, check the issued fields, play the XADC side, check the ack.
  task automatic serve(input int exp_idx, input int lat, input logic [15:0] rdata,
                       input logic [15:0] exp_do, input logic exp_err);
    int t;
    int exp_t;
    for (int i = 0; i < 10; i++) begin
      if (drp_den) break;
      tick();
    end
    check("den_seen", 32'(drp_den), 32'd1);
    check("daddr", 32'(drp_daddr), 32'(addr_tab[exp_idx]));
    check("dwe", 32'(drp_dwe), 32'(req_we[exp_idx]));
    check("di", 32'(drp_di), 32'(di_tab[exp_idx]));
    for (t = 1; t <= 40; t++) begin
      tick();
      drp_drdy = (t == lat);
      drp_do   = (t == lat) ? rdata : 16'h0000;
      if (t == 1) check("den_one_cycle", 32'(drp_den), 32'd0);
      if (ack != 4'b0000) break;
    end
    drp_drdy = 1'b0;
    exp_t = (lat > 0) ? lat + 1 : TO + 1;
    check("ack_latency", 32'(t), 32'(exp_t));
    check("ack_onehot", 32'(ack), 32'(4'b0001 << exp_idx));
    check("ack_do", 32'(ack_do), 32'(exp_do));
    check("ack_err", 32'(ack_err), 32'(exp_err));
  endtask

  initial begin
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int alt   [3] = '{1, 3, 1};

    vecs[0] = '{4'b0001, 4'b0000, 4,  16'hA5C0, 0, 16'hA5C0, 1'b0};
    vecs[1] = '{4'b0100, 4'b0100, 2,  16'hFFFF, 2, 16'h0000, 1'b0};
    vecs[2] = '{4'b1000, 4'b0000, -1, 16'h0000, 3, 16'h0000, 1'b1};
    vecs[3] = '{4'b0010, 4'b0000, 1,  16'h1234, 1, 16'h1234, 1'b0};
    vecs[4] = '{4'b0011, 4'b0000, 3,  16'h0BEE, 0, 16'h0BEE, 1'b0};
    vecs[5] = '{4'b1001, 4'b0000, 5,  16'h7777, 3, 16'h7777, 1'b0};
    vecs[6] = '{4'b0001, 4'b0000, 16, 16'hCAFE, 0, 16'hCAFE, 1'b0};

    resetn   = 1'b0;
    req      = '0;
    req_we   = '0;
    req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    req_di   = {di_tab[3], di_tab[2], di_tab[1], di_tab[0]};
    drp_do   = '0;
    drp_drdy = 1'b0;
    tick();
    tick();
    check("reset_ctrl", {26'd0, busy, ack, drp_den}, 32'd0);
    check("reset_drp", {8'd0, drp_dwe, drp_daddr, drp_di}, 32'd0);
    check("reset_ack", {15'd0, ack_err, ack_do}, 32'd0);
    resetn = 1'b1;
    tick();

    // Spurious drdy while idle
    drp_drdy = 1'b1;
    drp_do   = 16'hDEAD;
    tick();
    drp_drdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("spurious_idle", {27'd0, busy, ack}, 32'd0);
      tick();
    end

    foreach (vecs[v]) begin
      req_we = vecs[v].we;
      req    = vecs[v].req;
      serve(vecs[v].exp_idx, vecs[v].lat, vecs[v].rdata, vecs[v].exp_do, vecs[v].exp_err);
      req = '0;
      tick();
      check("idle_after", {27'd0, busy, ack}, 32'd0);
    end

    // Timeout followed by a late drdy that must be ignored
    req_we = '0;
    req    = 4'b0100;
    serve(2, -1, 16'h0000, 16'h0000, 1'b1);
    req = '0;
    tick();
    tick();
    tick();
    drp_drdy = 1'b1;
    drp_do   = 16'h5A5A;
    tick();
    drp_drdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_drdy", {27'd0, busy, ack}, 32'd0);
      tick();
    end

    // Reset while waiting for drdy; pointer must come back at 0
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      if (drp_den) break;
      tick();
    end
    check("rst_den_seen", 32'(drp_den), 32'd1);
    tick();
    tick();
    check("rst_in_wait", 32'(busy), 32'd1);
    resetn = 1'b0;
    req    = '0;
    tick();
    resetn = 1'b1;
    check("rst_mid_ctrl", {26'd0, busy, ack, drp_den}, 32'd0);
    check("rst_mid_drp", {8'd0, drp_dwe, drp_daddr, drp_di}, 32'd0);
    check("rst_mid_ack", {15'd0, ack_err, ack_do}, 32'd0);
    drp_drdy = 1'b1;
    drp_do   = 16'hFFFF;
    tick();
    drp_drdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_late_drdy", {27'd0, busy, ack}, 32'd0);
      tick();
    end
    req = 4'b1001;
    serve(0, 2, 16'h00AA, 16'h00AA, 1'b0);
    req = '0;
    tick();

    // Fairness with every requester held high
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      serve(order[i], 2, 16'h0100 + 16'(i), 16'h0100 + 16'(i), 1'b0);
    end
    req = '0;
    tick();
    do_reset();
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      serve(alt[i], 1, 16'h0200 + 16'(i), 16'h0200 + 16'(i), 1'b0);
    end
    req = '0;
    tick();
    check("final_idle", {27'd0, busy, ack}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
